// File: rtl/regfile_32x32_pkg.sv
// Shared constants for the 32x32 register file: geometry and architectural register indices.
package regfile_32x32_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;
endpackage

// File: rtl/reg_32bits_ar.sv
// One architectural register: loads d when en is high, cleared asynchronously by reset.
module reg_32bits_ar
  import regfile_32x32_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_32x32.sv
// Two-read, one-write register file with hardwired-zero r0 and optional write-to-read forwarding.
module regfile_32x32 #(
  parameter int DATA_W = regfile_32x32_pkg::DATA_W,
  parameter int ADDR_W = regfile_32x32_pkg::ADDR_W,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  import regfile_32x32_pkg::*;

  localparam int NUM = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM];
  logic              fwd_valid;

  // r0 has no storage; it is simply a constant zero on the read side.
  assign regs[REG_ZERO] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM; gi++) begin : g_reg
      logic wr_en;
      assign wr_en = we && (wa == ADDR_W'(gi));

      reg_32bits_ar #(
        .W(DATA_W)
      ) u_reg (
        .clk  (clk),
        .reset(reset),
        .en   (wr_en),
        .d    (wd),
        .q    (regs[gi])
      );
    end
  endgenerate

  assign fwd_valid = (BYPASS != 0) && we && (wa != ADDR_W'(REG_ZERO));

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (fwd_valid && (ra1 == wa)) begin
      rd1 = wd;
    end
    if (fwd_valid && (ra2 == wa)) begin
      rd2 = wd;
    end
    // Forwarded data must not leak out while the array is held in reset.
    if (reset) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

endmodule
